// File: rtl/uart_tx_unit_if.sv
// Host-side handshake bundle for uart_tx_unit.
//   tx_start     : start request from host (sampled only while the transmitter is idle)
//   tx_din       : word to send, captured when the request is accepted
//   tx           : serial line, idle high
//   tx_done_tick : one-clock pulse at the end of the stop period
// master: host logic; slave: the transmitter.
interface uart_tx_unit_if #(
  parameter int unsigned DBIT = 8
);
  logic            tx_start;
  logic [DBIT-1:0] tx_din;
  logic            tx;
  logic            tx_done_tick;

  modport master (
    output tx_start,
    output tx_din,
    input  tx,
    input  tx_done_tick
  );

  modport slave (
    input  tx_start,
    input  tx_din,
    output tx,
    output tx_done_tick
  );
endinterface

// File: rtl/uart_tx_unit.sv
// UART transmitter with an integrated programmable 16x baud-tick generator.
// Frame: start bit (0), DBIT data bits LSB first, stop period of SB_TICK ticks (line high).
//
// Ports:
//   clk          : system clock, rising edge
//   reset_n      : synchronous active-low reset
//   baud_en      : baud counter enable; counter holds and s_tick is low when deasserted
//   final_value  : baud terminal count; tick period is final_value+1 clocks
//   host         : uart_tx_unit_if.slave (tx_start, tx_din, tx, tx_done_tick)
//   s_tick       : baud tick, one clock wide
//   s_reg        : oversample tick counter (debug)
//   b_next       : data shift register (debug)
//   tx_reg       : registered serial bit, equal to host.tx
//   state_out    : FSM state, 0 IDLE, 1 START, 2 DATA, 3 STOP
//   tx_busy      : (only with UART_TX_BUSY_EN defined) registered state != IDLE
//
// Optional feature macro: UART_TX_BUSY_EN.
module uart_tx_unit #(
  parameter int unsigned DBIT    = 8,
  parameter int unsigned SB_TICK = 16,
  parameter int unsigned BITS    = 11
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            baud_en,
  input  logic [BITS-1:0] final_value,
  uart_tx_unit_if.slave   host,
  output logic            s_tick,
  output logic [3:0]      s_reg,
  output logic [DBIT-1:0] b_next,
  output logic            tx_reg,
  output logic [1:0]      state_out
`ifdef UART_TX_BUSY_EN
  ,
  output logic            tx_busy
`endif
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  // Tick counter must reach SB_TICK-1 in the stop period (up to 31 for two stop bits).
  localparam int unsigned SW = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;
  localparam int unsigned NW = (DBIT > 1) ? $clog2(DBIT) : 1;

  localparam logic [SW-1:0] SLast    = SW'(15);
  localparam logic [SW-1:0] StopLast = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] NLast    = NW'(DBIT - 1);

  // Baud generator
  logic [BITS-1:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (baud_en) begin
      q_d = (q_q == final_value) ? '0 : q_q + BITS'(1);
    end
  end

  assign s_tick = baud_en && (q_q == final_value);

  // Transmit FSM
  logic [1:0]      state_q, state_d;
  logic [SW-1:0]   s_q, s_d;
  logic [NW-1:0]   n_q, n_d;
  logic [DBIT-1:0] b_q, b_d;
  logic            tx_q, tx_next;
  logic            done;

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    b_d     = b_q;
    tx_next = 1'b1;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        tx_next = 1'b1;
        if (host.tx_start) begin
          b_d     = host.tx_din;
          s_d     = '0;
          state_d = START;
        end
      end
      START: begin
        tx_next = 1'b0;
        if (s_tick) begin
          if (s_q == SLast) begin
            s_d     = '0;
            n_d     = '0;
            state_d = DATA;
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end
      DATA: begin
        tx_next = b_q[0];
        if (s_tick) begin
          if (s_q == SLast) begin
            s_d = '0;
            b_d = b_q >> 1;
            if (n_q == NLast) begin
              state_d = STOP;
            end else begin
              n_d = n_q + NW'(1);
            end
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end
      STOP: begin
        tx_next = 1'b1;
        if (s_tick) begin
          if (s_q == StopLast) begin
            done    = 1'b1;
            state_d = IDLE;
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      q_q     <= '0;
      state_q <= IDLE;
      s_q     <= '0;
      n_q     <= '0;
      b_q     <= '0;
      tx_q    <= 1'b1;
    end else begin
      q_q     <= q_d;
      state_q <= state_d;
      s_q     <= s_d;
      n_q     <= n_d;
      b_q     <= b_d;
      tx_q    <= tx_next;
    end
  end

`ifdef UART_TX_BUSY_EN
  logic busy_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      busy_q <= 1'b0;
    end else begin
      busy_q <= (state_d != IDLE);
    end
  end

  assign tx_busy = busy_q;
`endif

  assign host.tx           = tx_q;
  assign host.tx_done_tick = done;
  assign tx_reg            = tx_q;
  assign s_reg             = s_q[3:0];
  assign b_next            = b_q;
  assign state_out         = state_q;

endmodule

// File: tb/tb_uart_tx_unit.sv
// Self-checking bench for uart_tx_unit: a tick-counting frame model is compared against the
// DUT on every clock, plus directed timing checks on baud period, gating and frame shapes.
`timescale 1ns/1ps
module tb_uart_tx_unit;
  localparam int unsigned DBIT    = 8;
  localparam int unsigned SB_TICK = 16;
  localparam int unsigned BITS    = 11;
  localparam int FV_BAUD  = 650;
  localparam int FV_FRAME = 50;
  localparam int TP       = FV_FRAME + 1;
  localparam int BIT_CLKS = 16 * TP;
  localparam int TOTAL    = 16 + 16 * DBIT + SB_TICK;
  localparam int QMASK    = (1 << BITS) - 1;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic            baud_en = 1'b0;
  logic [BITS-1:0] final_value = BITS'(FV_BAUD);
  logic            s_tick;
  logic [3:0]      s_reg;
  logic [DBIT-1:0] b_next;
  logic            tx_reg;
  logic [1:0]      state_out;
`ifdef UART_TX_BUSY_EN
  logic            tx_busy;
`endif

  uart_tx_unit_if #(.DBIT(DBIT)) bus ();

  uart_tx_unit #(
    .DBIT   (DBIT),
    .SB_TICK(SB_TICK),
    .BITS   (BITS)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .baud_en    (baud_en),
    .final_value(final_value),
    .host       (bus),
    .s_tick     (s_tick),
    .s_reg      (s_reg),
    .b_next     (b_next),
    .tx_reg     (tx_reg),
    .state_out  (state_out)
`ifdef UART_TX_BUSY_EN
    ,
    .tx_busy    (tx_busy)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Frame model: a frame is a count of ticks t since acceptance; state, s_reg, b_next and the
  // line value all follow from t and the captured word.
  int              mq = 0;
  int              t = 0;
  bit              m_busy = 1'b0;
  bit              m_valid = 1'b0;
  logic            m_tx = 1'b1;
  logic [DBIT-1:0] m_b = '0;
  logic [3:0]      m_sidle = 4'd0;

  initial begin
    forever begin
      @(negedge clk);
      begin : step
        int   est;
        int   esr;
        logic m_tick;
        logic edone;
        logic txnext;
        m_tick = baud_en && (mq == int'(final_value));
        if (!m_busy) begin
          est = 0; esr = int'(m_sidle);
        end else if (t < 16) begin
          est = 1; esr = t;
        end else if (t < 16 + 16 * DBIT) begin
          est = 2; esr = (t - 16) % 16;
        end else begin
          est = 3; esr = t - 16 - 16 * DBIT;
        end
        edone = m_busy && (est == 3) && m_tick && (t == TOTAL - 1);
        if (m_valid) begin
          chk("cyc_tx", bus.tx, m_tx);
          chk("cyc_tx_reg", tx_reg, m_tx);
          chk("cyc_s_tick", s_tick, m_tick);
          chk("cyc_state", state_out, est);
          chk("cyc_s_reg", s_reg, esr & 15);
          chk("cyc_b_next", b_next, m_b);
          chk("cyc_done", bus.tx_done_tick, edone);
`ifdef UART_TX_BUSY_EN
          chk("cyc_busy", tx_busy, est != 0);
`endif
        end
        if (!reset_n) begin
          mq = 0; m_busy = 1'b0; t = 0; m_b = '0; m_tx = 1'b1; m_sidle = 4'd0;
          m_valid = 1'b1;
        end else begin
          txnext = (est == 1) ? 1'b0 : (est == 2) ? m_b[0] : 1'b1;
          m_tx = txnext;
          if (baud_en) mq = (mq == int'(final_value)) ? 0 : ((mq + 1) & QMASK);
          if (!m_busy) begin
            if (bus.tx_start) begin
              m_busy = 1'b1; t = 0; m_b = bus.tx_din;
            end
          end else if (m_tick) begin
            t++;
            if (t >= 32 && t <= 16 + 16 * DBIT && (t % 16) == 0) m_b = m_b >> 1;
            if (t == TOTAL) begin
              m_busy = 1'b0;
              m_sidle = 4'((SB_TICK - 1) & 15);
            end
          end
        end
      end
    end
  end

  // Event recorder for the directed timing checks.
  int   starts_q[$];
  int   done_q[$];
  int   txe_q[$];
  int   tick_cnt = 0;
  int   done_hi = 0;
  logic [1:0] p_state = 2'd0;
  logic p_tx = 1'b1;

  initial begin
    forever begin
      @(negedge clk);
      if (reset_n) begin
        if (state_out == 2'd1 && p_state == 2'd0) starts_q.push_back(cyc);
        if (bus.tx !== p_tx) txe_q.push_back(cyc);
        if (bus.tx_done_tick === 1'b1) begin
          done_hi++;
          done_q.push_back(cyc);
        end
        if (s_tick === 1'b1) tick_cnt++;
      end
      p_state = state_out;
      p_tx = bus.tx;
    end
  end

  task automatic clear_events();
    starts_q.delete();
    done_q.delete();
    txe_q.delete();
    done_hi = 0;
  endtask

  task automatic wait_tick(output int c);
    int i;
    i = 0;
    do begin
      @(negedge clk); #1;
      i++;
    end while (s_tick !== 1'b1 && i < 5000);
    chk("tick_seen", s_tick, 1'b1);
    c = cyc;
  endtask

  initial begin
    int c0, c1, c2, tk0, d, i;
    bus.tx_start = 1'b0;
    bus.tx_din = '0;

    // Reset
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    chk("rst_tx", bus.tx, 1'b1);
    chk("rst_state", state_out, 2'd0);
    chk("rst_s_reg", s_reg, 4'd0);
    chk("rst_b_next", b_next, 8'd0);
    chk("rst_done", bus.tx_done_tick, 1'b0);
    chk("rst_s_tick", s_tick, 1'b0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    baud_en = 1'b1;

    // Baud period and gating
    wait_tick(c0);
    wait_tick(c1);
    chk("tick_period", c1 - c0, FV_BAUD + 1);
    @(negedge clk); #1;
    chk("tick_width", s_tick, 1'b0);
    wait_tick(c1);
    @(posedge clk);
    repeat (100) @(posedge clk);
    #1;
    baud_en = 1'b0;
    tk0 = tick_cnt;
    repeat (200) @(posedge clk);
    #1;
    chk("gated_ticks", tick_cnt - tk0, 0);
    baud_en = 1'b1;
    wait_tick(c2);
    chk("gated_period", c2 - c1, FV_BAUD + 1 + 200);

    // Frame 0xAA with a busy-time request that must be ignored
    @(posedge clk); #1;
    final_value = BITS'(FV_FRAME);
    clear_events();
    bus.tx_din = 8'hAA;
    bus.tx_start = 1'b1;
    @(posedge clk); #1;
    bus.tx_start = 1'b0;
    bus.tx_din = 8'h00;
    repeat (3 * BIT_CLKS) @(posedge clk);
    #1;
    chk("ign_in_data", state_out, 2'd2);
    bus.tx_din = 8'h55;
    bus.tx_start = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    bus.tx_start = 1'b0;
    i = 0;
    while (done_q.size() < 1 && i < 12 * BIT_CLKS) begin
      @(negedge clk); #1;
      i++;
    end
    chk("aa_done_seen", done_q.size(), 1);
    @(negedge clk); #1;
    chk("aa_idle_after", state_out, 2'd0);
    repeat (2000) @(posedge clk);
    #1;
    chk("aa_one_start", starts_q.size(), 1);
    chk("aa_done_pulses", done_hi, 1);
    chk("aa_tx_edges", txe_q.size(), 8);
    if (txe_q.size() == 8 && starts_q.size() >= 1 && done_q.size() >= 1) begin
      chk("aa_tx_lag", txe_q[0] - starts_q[0], 1);
      d = txe_q[1] - txe_q[0];
      chk("aa_start_len", (d >= BIT_CLKS + 15 * TP + 1) && (d <= BIT_CLKS + 16 * TP), 1'b1);
      for (int k = 1; k < 7; k++) chk("aa_bit_len", txe_q[k+1] - txe_q[k], BIT_CLKS);
      chk("aa_stop_len", done_q[0] - txe_q[7], 2 * BIT_CLKS - 2);
    end

    // Back-to-back frames at one tick per clock
    @(posedge clk); #1;
    final_value = '0;
    wait_tick(c0);
    @(posedge clk); #1;
    clear_events();
    bus.tx_din = 8'h0F;
    bus.tx_start = 1'b1;
    i = 0;
    while (starts_q.size() < 1 && i < 20) begin
      @(negedge clk); #1;
      i++;
    end
    @(posedge clk); #1;
    bus.tx_din = 8'hF0;
    i = 0;
    while (starts_q.size() < 2 && i < 400) begin
      @(negedge clk); #1;
      i++;
    end
    @(posedge clk); #1;
    bus.tx_start = 1'b0;
    i = 0;
    while (done_q.size() < 2 && i < 400) begin
      @(negedge clk); #1;
      i++;
    end
    repeat (50) @(posedge clk);
    #1;
    chk("b2b_starts", starts_q.size(), 2);
    chk("b2b_done_pulses", done_hi, 2);
    chk("b2b_tx_edges", txe_q.size(), 6);
    if (starts_q.size() == 2 && done_q.size() == 2) begin
      chk("b2b_len0", done_q[0] - starts_q[0], TOTAL - 1);
      chk("b2b_len1", done_q[1] - starts_q[1], TOTAL - 1);
      chk("b2b_gap", starts_q[1] - done_q[0], 2);
    end
    if (txe_q.size() == 6) begin
      chk("b2b_start_bit", txe_q[1] - txe_q[0], 16);
      chk("b2b_ones_0f", txe_q[2] - txe_q[1], 64);
      chk("b2b_zeros_0f", txe_q[3] - txe_q[2], 64);
      chk("b2b_low_f0", txe_q[5] - txe_q[4], 80);
    end

    // Reset in the middle of a frame
    @(posedge clk); #1;
    bus.tx_din = 8'h3C;
    bus.tx_start = 1'b1;
    @(posedge clk); #1;
    bus.tx_start = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    chk("mid_busy", state_out, 2'd2);
    reset_n = 1'b0;
    @(posedge clk);
    @(negedge clk); #1;
    chk("mid_rst_tx", bus.tx, 1'b1);
    chk("mid_rst_state", state_out, 2'd0);
    chk("mid_rst_b_next", b_next, 8'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_unit.md
Name: uart_tx_unit

Overview:
- UART transmitter with an integrated programmable baud-tick generator.
- Generates a 16x-oversampling tick from the system clock using a runtime terminal count.
- Serialises one DBIT-wide word as start bit, data bits LSB first, then stop period.
- Sits between the host logic (tx_start/tx_din handshake) and the serial pin; exposes FSM internals for debug.

Parameters:
- DBIT, 8, number of data bits per frame.
- SB_TICK, 16, stop period length in s_ticks (16 = 1 stop bit, 24 = 1.5, 32 = 2).
- BITS, 11, width of the baud counter and the final_value port.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset_n  in  1  synchronous, active-low reset.
- baud_en  in  1  baud counter enable; counter holds when low.
- final_value  in  BITS  baud terminal count; tick period is final_value+1 clocks (650 at 100 MHz gives 9600 baud x16).
- tx_start  in  1  start request, sampled only in IDLE.
- tx_din  in  DBIT  word to send, captured when the request is accepted.
- tx  out  1  serial output; idle high.
- tx_done_tick  out  1  one-clock pulse at the end of the stop period.
- s_tick  out  1  baud tick, one clock wide.
- s_reg  out  4  oversample tick counter (debug).
- b_next  out  DBIT  data shift register contents (debug).
- tx_reg  out  1  registered serial bit (equal to tx).
- state_out  out  2  FSM state: 0 IDLE, 1 START, 2 DATA, 3 STOP.

Behaviour:
- Reset (reset_n low at a clock edge):
  - Baud counter q = 0; s_tick = 0.
  - state = IDLE; s_reg = 0; bit counter n = 0; b_next = 0.
  - tx_reg = 1; tx_done_tick = 0.
  - Reset mid-frame aborts the frame; tx returns high on the next clock.
- Baud generator:
  - With baud_en high: q increments each clock.
  - When q == final_value, q wraps to 0 on the next clock.
  - s_tick = (q == final_value) and is combinational from q, so it is high for exactly one clock per final_value+1 clocks.
  - With baud_en low: q holds and s_tick is forced low.
  - final_value = 0 gives s_tick high every enabled clock.
  - final_value changes take effect on the next compare.
- FSM: s_reg and n are updated only on clocks with s_tick high, except where stated.
  - IDLE:
    - tx_next = 1.
    - On tx_start: b_next <= tx_din, s_reg <= 0, go to START. No s_tick is needed.
  - START:
    - tx_next = 0.
    - On s_tick: if s_reg == 15, then s_reg <= 0, n <= 0, go to DATA; otherwise s_reg++.
  - DATA:
    - tx_next = b_next[0].
    - On s_tick with s_reg == 15: s_reg <= 0 and b_next <= b_next >> 1 (zero fill).
    - At that point, if n == DBIT-1, go to STOP; otherwise n++.
    - On s_tick with s_reg != 15: s_reg++.
  - STOP:
    - tx_next = 1.
    - On s_tick: if s_reg == SB_TICK-1, then tx_done_tick = 1 for that clock and go to IDLE; otherwise s_reg++.
- Output register: tx_reg <= tx_next every clock, and tx = tx_reg. The line therefore lags state_out by one clock.
- tx_start is ignored outside IDLE, and tx_din is not re-sampled mid-frame.
- tx_start held high in IDLE on the same clock tx_done_tick fires is not accepted until the clock after return to IDLE. Back-to-back frames therefore have no gap beyond one clock.
- The first START tick may arrive anywhere within one tick period, so the start bit lasts 15 to 16 tick periods.
- Every data bit lasts exactly 16 tick periods.
- The stop period lasts SB_TICK tick periods.

Optional Feature:
- Macro UART_TX_BUSY_EN.
- When defined: adds output tx_busy (1 bit), equal to (state != IDLE), registered identically to state_out, reset 0.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset: hold reset_n low 2 clocks -> tx = 1, state_out = 0, s_reg = 0, b_next = 0, tx_done_tick = 0, s_tick = 0.
- Baud tick: final_value = 650, baud_en = 1 -> s_tick pulses exactly every 651 clocks, each one clock wide.
- Baud gating: baud_en = 0 -> s_tick stays low and q holds; re-enable -> counting resumes from the held value.
- Frame 0xAA (final_value 650, SB_TICK 16): pulse tx_start for 1 clock ->
  - tx goes 0 one clock after state_out = 1;
  - then tx shows 0,1,0,1,0,1,0,1, each 16x651 = 10416 clocks;
  - then tx = 1 for 10416 clocks;
  - tx_done_tick is a single-clock pulse and state_out returns to 0.
- Busy ignore: assert tx_start with tx_din = 0x55 during the DATA state of a 0xAA frame -> the frame still carries 0xAA and no second frame starts.
- Back-to-back, final_value = 0: tx_din 0x0F then 0xF0, tx_start held high -> two frames, each bit 16 clocks, and tx_done_tick pulses twice.
